// File: rtl/ik_swift_sequencer.sv
// ik_swift_sequencer: iteration controller wrapping the ik_swift core.
// Loads the DH table, runs core iterations and stops on convergence, limit or timeout.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   start               level request; rising edge launches a run
//   joint_type[NJ]      1 = rotational (compare THETA), 0 = prismatic (compare L_OFFSET)
//   tol[W]              unsigned convergence tolerance
//   iter_limit[8]       max iterations (0 behaves as 1)
//   dh_init[DH]         initial DH table, sampled on launch
//   core_rst/core_en    core clear pulse / enable
//   core_dh_in[DH]      working table to core
//   core_done           core iteration complete, core_dh_out valid
//   core_dh_out[DH]     updated table from core
//   busy/done/status    run state and outcome (01 conv, 10 limit, 11 timeout)
//   iter_count[8]       completed iterations
//   dh_result[DH]       working table, final once done
module ik_swift_sequencer #(
    parameter int NJ      = 6,
    parameter int W       = 36,
    parameter int TIMEOUT = 4096,
    parameter int DH      = NJ * 4 * W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [NJ-1:0] joint_type,
    input  logic [W-1:0]  tol,
    input  logic [7:0]    iter_limit,
    input  logic [DH-1:0] dh_init,
    output logic          core_rst,
    output logic          core_en,
    output logic [DH-1:0] core_dh_in,
    input  logic          core_done,
    input  logic [DH-1:0] core_dh_out,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [7:0]    iter_count,
    output logic [DH-1:0] dh_result
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int JW = (NJ > 1) ? $clog2(NJ) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NJ - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic          start_q;
    logic [DH-1:0] dh_work;
    logic [DH-1:0] dh_next;
    logic [TW-1:0] timer;
    logic [JW-1:0] j;
    logic          nc;

    logic          launch;
    logic [W-1:0]  w_f;
    logic [W-1:0]  n_f;
    logic [W:0]    d;
    logic [W:0]    ad;
    logic          exceed;
    logic          nc_all;
    logic [7:0]    lim;
    logic          limit_hit;
    logic [7:0]    cnt_inc;

    assign launch     = start & ~start_q;
    assign core_rst   = (state == S_LOAD);
    assign core_en    = (state == S_RUN);
    assign busy       = (state == S_LOAD) | (state == S_RUN) | (state == S_CHECK);
    assign done       = (state == S_DONE);
    assign core_dh_in = dh_work;
    assign dh_result  = dh_work;

    // Pick the compared field of joint j from both tables.
    always_comb begin
        w_f = '0;
        n_f = '0;
        for (int k = 0; k < NJ; k++) begin
            if (j == JW'(k)) begin
                if (joint_type[k]) begin
                    w_f = dh_work[(4*k)*W +: W];
                    n_f = dh_next[(4*k)*W +: W];
                end else begin
                    w_f = dh_work[(4*k+1)*W +: W];
                    n_f = dh_next[(4*k+1)*W +: W];
                end
            end
        end
    end

    // One extra bit keeps the full signed difference and its magnitude exact.
    always_comb begin
        d         = {n_f[W-1], n_f} - {w_f[W-1], w_f};
        ad        = d[W] ? (~d + 1'b1) : d;
        exceed    = ad > {1'b0, tol};
        nc_all    = nc | exceed;
        lim       = (iter_limit == 8'd0) ? 8'd1 : iter_limit;
        limit_hit = ({1'b0, iter_count} + 9'd1) >= {1'b0, lim};
        cnt_inc   = (iter_count == 8'hFF) ? iter_count : iter_count + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            dh_work    <= '0;
            dh_next    <= '0;
            timer      <= '0;
            j          <= '0;
            nc         <= 1'b0;
            status     <= 2'b00;
            iter_count <= 8'd0;
        end else begin
            start_q <= start;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        dh_work    <= dh_init;
                        iter_count <= 8'd0;
                        status     <= 2'b00;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!start) begin
                        status <= 2'b00;
                        state  <= S_IDLE;
                    end else begin
                        timer <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!start) begin
                        status <= 2'b00;
                        state  <= S_IDLE;
                    end else if (core_done) begin
                        dh_next <= core_dh_out;
                        j       <= '0;
                        nc      <= 1'b0;
                        state   <= S_CHECK;
                    end else if (timer == T_LAST) begin
                        status <= 2'b11;
                        state  <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!start) begin
                        status <= 2'b00;
                        state  <= S_IDLE;
                    end else if (j == J_LAST) begin
                        dh_work    <= dh_next;
                        iter_count <= cnt_inc;
                        if (!nc_all) begin
                            status <= 2'b01;
                            state  <= S_DONE;
                        end else if (limit_hit) begin
                            status <= 2'b10;
                            state  <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else begin
                        j  <= j + 1'b1;
                        nc <= nc_all;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
